// File: rtl/nios_system_keycode_rx.sv
// nios_system_keycode_rx
// Avalon-MM slave that captures keycode changes from an external peripheral
// into a 4-entry x 16-bit FIFO and raises a level interrupt while entries are
// queued or an overflow has occurred.
//
// Optional feature macro: KEYCODE_RX_SYNC_EN
//   defined   -> in_port passes through a 2-flop synchronizer before compare
//   undefined -> in_port is compared directly
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     synchronous active-low reset
//   address     register select (0 data/pop, 1 status, 2 irq_mask, 3 raw)
//   chipselect  slave select
//   read_n      active-low read strobe
//   write_n     active-low write strobe
//   writedata   write data
//   in_port     keycode input, asynchronous to clk
//   readdata    combinational read data (latency 0)
//   irq         registered level interrupt
module nios_system_keycode_rx (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic [15:0] in_port,
  output logic [31:0] readdata,
  output logic        irq
);

  logic [15:0] sampled;
  logic [15:0] last_q;
  logic [15:0] mem_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q, count_d;
  logic        overflow_q, overflow_d;
  logic        irq_mask_q;
  logic        irq_q;

  logic rd_acc, wr_acc;
  logic push, pop, push_ok, full, empty;
  logic ovf_clear;

`ifdef KEYCODE_RX_SYNC_EN
  logic [15:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 16'h0;
      sync2_q <= 16'h0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  assign sampled = sync2_q;
`else
  assign sampled = in_port;
`endif

  assign rd_acc    = chipselect && !read_n;
  assign wr_acc    = chipselect && !write_n;
  assign empty     = (count_q == 3'd0);
  assign full      = (count_q == 3'd4);
  assign push      = (sampled != last_q);
  assign pop       = rd_acc && (address == 2'd0) && !empty;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign push_ok   = push && (!full || pop);
  assign ovf_clear = wr_acc && (address == 2'd1) && writedata[8];

  always_comb begin
    count_d = count_q + {2'b00, push_ok} - {2'b00, pop};
  end

  always_comb begin
    overflow_d = overflow_q;
    if (ovf_clear) begin
      overflow_d = 1'b0;
    end
    // A dropped push is the newer event and wins over a clear.
    if (push && !push_ok) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_q     <= 16'h0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
      irq_mask_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (push) begin
        last_q <= sampled;
      end
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (wr_acc && (address == 2'd2)) begin
        irq_mask_q <= writedata[0];
      end
      irq_q <= irq_mask_q && (!empty || overflow_q);
    end
  end

  // Storage needs no reset: contents are only visible when count is nonzero.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= sampled;
    end
  end

  always_comb begin
    readdata = 32'h0;
    unique case (address)
      2'd0: readdata = empty ? 32'h0 : {1'b1, 15'h0, mem_q[rd_ptr_q]};
      2'd1: readdata = {23'h0, overflow_q, 5'h0, count_q};
      2'd2: readdata = {31'h0, irq_mask_q};
      2'd3: readdata = {16'h0, sampled};
      default: readdata = 32'h0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: doc/nios_system_keycode_rx.md
NIOS_SYSTEM_KEYCODE_RX -- requirements
Module: nios_system_keycode_rx

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-003 SHALL have port address  input  2  Avalon-MM register select.
REQ-004 SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-005 SHALL have port read_n  input  1  active-low read strobe; a read access is chipselect && !read_n.
REQ-006 SHALL have port write_n  input  1  active-low write strobe; a write access is chipselect && !write_n.
REQ-007 SHALL have port writedata  input  32  write data.
REQ-008 SHALL have port in_port  input  16  keycode from the peripheral, asynchronous to clk.
REQ-009 SHALL have port readdata  output  32  read data, combinational from address and state (read latency 0).
REQ-010 SHALL have port irq  output  1  level interrupt to the CPU.

Function
REQ-011 SHALL hold the sampled keycode in last[15:0]; whenever the sampled value differs from last, last SHALL take the sampled value and that value SHALL be pushed into a 4-entry x 16-bit FIFO in the same cycle.
REQ-012 SHALL keep count[2:0] in the range 0..4; the FIFO is empty at count 0 and full at count 4, with the pointers wrapping modulo 4.
REQ-013 Address 0 read SHALL return {valid, 15'b0, head[15:0]}, where valid = (count != 0); when the FIFO is empty, readdata[15:0] SHALL be 0.
REQ-014 A read access at address 0 with count != 0 SHALL pop the head at that clock edge; a pop on an empty FIFO SHALL be ignored.
REQ-015 Address 1 read SHALL return {23'b0, overflow, 5'b0, count[2:0]}, with overflow at bit 8.
REQ-016 A write at address 1 with writedata[8]=1 SHALL clear overflow; writedata[8]=0 SHALL have no effect.
REQ-017 Address 2 SHALL be the irq_mask register: a write sets irq_mask <= writedata[0], and a read returns {31'b0, irq_mask}.
REQ-018 Address 3 read SHALL return {16'b0, sampled in_port}, with no side effects.
REQ-019 A push while full SHALL be dropped and SHALL set overflow to 1; last SHALL still update.
REQ-020 A push and a pop in the same cycle SHALL both succeed and leave count unchanged, including when the FIFO is full.
REQ-021 irq SHALL equal irq_mask && ((count != 0) || overflow), registered, so it is asserted one cycle after the condition becomes true.
REQ-022 If a pop and a clear of overflow coincide with a push-while-full, overflow SHALL NOT be set, because the push succeeds per REQ-020.
REQ-023 Writes to address 0 and 3 SHALL be ignored, and any read other than a read at address 0 SHALL have no side effects.

Reset
REQ-024 While reset_n=0 at a clock edge, the block SHALL set: FIFO empty, count=0, pointers=0, overflow=0, irq_mask=0, irq=0, last=0, synchronizer flops=0.
REQ-025 A reset mid-operation SHALL discard all queued keycodes.
REQ-026 Because last resets to 0, a nonzero in_port present at reset release SHALL be captured as a new keycode.

Configuration
REQ-027 When KEYCODE_RX_SYNC_EN is defined, in_port SHALL pass through a 2-flop synchronizer, and a value stable before edge k SHALL be pushed at edge k+2.
REQ-028 When KEYCODE_RX_SYNC_EN is undefined, in_port SHALL be compared directly, and a value stable before edge k SHALL be pushed at edge k.
REQ-029 The address 3 readback SHALL reflect the synchronizer output when KEYCODE_RX_SYNC_EN is defined, and in_port directly when it is not.

Verification
REQ-030 Reset, then in_port=0x001A with SYNC_EN defined -> readdata at address 0 = 0x8000001A after edge 2 following the change, and count=1.
REQ-031 Apply changes 0x04, 0x05, 0x06, 0x07, 0x08 with no reads -> count=4, overflow=1, and pops return 0x04..0x07; a fifth pop returns 0x00000000 with count unchanged.
REQ-032 With the FIFO full, push 0x09 in the same cycle as a pop of address 0 -> count stays 4, overflow stays 0, and 0x09 is the tail.
REQ-033 Write irq_mask=1, then capture 0x0016 -> irq=1 one cycle after the push; pop the entry -> irq=0 one cycle later; write 1 to address 1 bit 8 -> overflow cleared.
REQ-034 Queue 2 entries, pulse reset_n=0 for 1 cycle while in_port=0x0000 -> count=0, irq=0, irq_mask=0, and address 0 reads 0x00000000.
